matrix_xfer_ctrl: RTL and testbench

Sequencer that sits directly upstream of memory_mod and moves whole matrices between the coprocessor register bank and RAM. It runs one memory_mod handshake per word: hold start, wait done, drop start for one cycle. It accepts a command of base address, length and direction. For reads it returns a flat matrix bus; for writes it stores a snapshot of the bank's matrix bus. This keeps the ALU/control FSM free of per-word memory handshaking.

---
 rtl/coproc_pkg.sv | 30 +++
 rtl/matrix_xfer_ctrl.sv | 114 +++++++++++
 tb/tb_matrix_xfer_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/coproc_pkg.sv
// Shared constants, transfer-state encoding and command payload for the coprocessor memory path.
package coproc_pkg;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned MAX_WORDS = 25;
    localparam int unsigned LEN_W     = 5;
    localparam int unsigned MAT_W     = MAX_WORDS * DATA_W;

    typedef enum logic [1:0] {
        XFER_IDLE    = 2'd0,
        XFER_ISSUE   = 2'd1,
        XFER_RELEASE = 2'd2,
        XFER_DONE    = 2'd3
    } xfer_state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] base;
        logic [LEN_W-1:0]  len;
    } xfer_cmd_t;

    // Rejects empty, oversize, or address-wrapping commands.
    function automatic logic cmd_is_bad(input xfer_cmd_t cmd);
        logic [ADDR_W:0] last;
        last = (ADDR_W+1)'(cmd.base) + (ADDR_W+1)'(cmd.len) - (ADDR_W+1)'(1);
        return (cmd.len == '0) || (cmd.len > LEN_W'(MAX_WORDS)) || last[ADDR_W];
    endfunction

endpackage

// File: rtl/matrix_xfer_ctrl.sv
// Moves whole matrices between the register bank and RAM, running one
// memory_mod start/done handshake per word with a one-cycle release gap.
module matrix_xfer_ctrl
    import coproc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [MAT_W-1:0]  wr_matrix,
    output logic [MAT_W-1:0]  rd_matrix,
    output logic              xfer_done,
    output logic              xfer_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_start,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_done
);

    xfer_state_e                        state_q;
    logic [MAX_WORDS-1:0][DATA_W-1:0]   buf_q;
    logic [LEN_W-1:0]                   idx_q;
    logic [LEN_W-1:0]                   len_q;
    logic                               dir_q;

    xfer_cmd_t                          cmd_c;
    logic                               cmd_bad_c;
    logic [LEN_W-1:0]                   nxt_idx_c;

    assign cmd_c     = '{write: cmd_write, base: cmd_base, len: cmd_len};
    assign cmd_bad_c = cmd_is_bad(cmd_c);
    assign nxt_idx_c = idx_q + LEN_W'(1);
    assign rd_matrix = buf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= XFER_IDLE;
            buf_q       <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            dir_q       <= 1'b0;
            cmd_ready   <= 1'b1;
            xfer_done   <= 1'b0;
            xfer_err    <= 1'b0;
            mem_address <= '0;
            mem_data_in <= '0;
            mem_start   <= 1'b0;
            mem_wr      <= 1'b0;
        end else begin
            xfer_done <= 1'b0;
            xfer_err  <= 1'b0;
            unique case (state_q)
                XFER_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_bad_c) begin
                            xfer_err <= 1'b1;
                        end else begin
                            len_q       <= cmd_c.len;
                            dir_q       <= cmd_c.write;
                            idx_q       <= '0;
                            mem_address <= cmd_c.base;
                            mem_wr      <= cmd_c.write;
                            mem_start   <= 1'b1;
                            cmd_ready   <= 1'b0;
                            state_q     <= XFER_ISSUE;
                            if (cmd_c.write) begin
                                buf_q       <= wr_matrix;
                                mem_data_in <= wr_matrix[DATA_W-1:0];
                            end else begin
                                mem_data_in <= buf_q[0];
                                for (int i = 0; i < MAX_WORDS; i++) begin
                                    if (LEN_W'(i) >= cmd_c.len) buf_q[i] <= '0;
                                end
                            end
                        end
                    end
                end
                XFER_ISSUE: begin
                    if (mem_done) begin
                        if (!dir_q) buf_q[idx_q] <= mem_data_out;
                        mem_start <= 1'b0;
                        if (idx_q == len_q - LEN_W'(1)) begin
                            xfer_done <= 1'b1;
                            state_q   <= XFER_DONE;
                        end else begin
                            state_q   <= XFER_RELEASE;
                        end
                    end
                end
                // memory_mod's done is still high here; it is deliberately not sampled.
                XFER_RELEASE: begin
                    idx_q       <= nxt_idx_c;
                    mem_address <= mem_address + ADDR_W'(1);
                    mem_data_in <= buf_q[nxt_idx_c];
                    mem_start   <= 1'b1;
                    state_q     <= XFER_ISSUE;
                end
                XFER_DONE: begin
                    cmd_ready <= 1'b1;
                    state_q   <= XFER_IDLE;
                end
                default: begin
                    state_q <= XFER_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_xfer_ctrl.sv
// Randomized self-checking bench for matrix_xfer_ctrl against a RAM stand-in
// and a whole-transfer reference model of RAM contents and the matrix buffer.
module tb_matrix_xfer_ctrl;
    import coproc_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_base;
    logic [LEN_W-1:0]  cmd_len;
    logic [MAT_W-1:0]  wr_matrix;
    logic [MAT_W-1:0]  rd_matrix;
    logic              xfer_done;
    logic              xfer_err;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_start;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_done;

    matrix_xfer_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_base     (cmd_base),
        .cmd_len      (cmd_len),
        .wr_matrix    (wr_matrix),
        .rd_matrix    (rd_matrix),
        .xfer_done    (xfer_done),
        .xfer_err     (xfer_err),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_start    (mem_start),
        .mem_wr       (mem_wr),
        .mem_data_out (mem_data_out),
        .mem_done     (mem_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory_mod stand-in: done rises on the third edge that sees start, clears when start drops.
    logic [DATA_W-1:0] mem_ram [0:255];
    logic [1:0]        mem_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_done     <= 1'b0;
            mem_cnt      <= 2'd0;
            mem_data_out <= '0;
        end else if (!mem_start) begin
            mem_done <= 1'b0;
            mem_cnt  <= 2'd0;
        end else if (!mem_done) begin
            if (mem_cnt == 2'd2) begin
                mem_done <= 1'b1;
                if (mem_wr) mem_ram[mem_address] <= mem_data_in;
                else        mem_data_out <= mem_ram[mem_address];
            end else begin
                mem_cnt <= mem_cnt + 2'd1;
            end
        end
    end

    logic [DATA_W-1:0] ref_ram [0:255];
    logic [MAT_W-1:0]  ref_buf;
    int                n_vec;
    int                n_err;

    task automatic check_eq(input string tag, input logic [MAT_W-1:0] got, input logic [MAT_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [MAT_W-1:0] rand_mat();
        logic [MAT_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_WORDS; i++) r[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        return r;
    endfunction

    // Reference effect of an accepted read on the buffer.
    task automatic model_read(input int base, input int len);
        ref_buf = '0;
        for (int i = 0; i < len; i++) ref_buf[i*DATA_W +: DATA_W] = ref_ram[base+i];
    endtask

    task automatic run_cmd(input logic wr, input int base, input int len, input logic [MAT_W-1:0] mat);
        logic bad;
        int   k;
        int   starts;
        bad = (len == 0) || (len > int'(MAX_WORDS)) || (base + len - 1 > 255);
        @(negedge clk);
        check_eq("ready_before_cmd", MAT_W'(cmd_ready), MAT_W'(1));
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_base  = base[ADDR_W-1:0];
        cmd_len   = len[LEN_W-1:0];
        wr_matrix = mat;
        @(negedge clk);
        cmd_valid = 1'b0;
        wr_matrix = rand_mat();
        if (bad) begin
            check_eq("err_pulse", MAT_W'(xfer_err), MAT_W'(1));
            check_eq("err_no_start", MAT_W'(mem_start), MAT_W'(0));
            check_eq("err_ready", MAT_W'(cmd_ready), MAT_W'(1));
            @(negedge clk);
            check_eq("err_fall", MAT_W'(xfer_err), MAT_W'(0));
            check_eq("err_no_start2", MAT_W'(mem_start), MAT_W'(0));
            check_eq("err_buf_kept", rd_matrix, ref_buf);
            return;
        end
        if (wr) begin
            for (int i = 0; i < len; i++) ref_ram[base+i] = mat[i*DATA_W +: DATA_W];
            ref_buf = mat;
        end else begin
            model_read(base, len);
        end
        k = 1;
        starts = 0;
        while (k <= 200) begin
            if (mem_start) starts++;
            if ((k % 5) == 1 && k <= 5*len) begin
                check_eq("word_addr", MAT_W'(mem_address), MAT_W'((base + (k-1)/5) & 255));
                check_eq("word_wr", MAT_W'(mem_wr), MAT_W'(wr));
                if (wr) check_eq("word_data", MAT_W'(mem_data_in), MAT_W'(mat[((k-1)/5)*DATA_W +: DATA_W]));
            end
            if (xfer_done) break;
            k++;
            @(negedge clk);
            wr_matrix = rand_mat();
        end
        check_eq("done_latency", MAT_W'(k), MAT_W'(5*len));
        check_eq("start_cycles", MAT_W'(starts), MAT_W'(4*len));
        check_eq("rd_matrix", rd_matrix, ref_buf);
        if (wr) begin
            for (int i = 0; i < len; i++)
                check_eq("ram_word", MAT_W'(mem_ram[base+i]), MAT_W'(ref_ram[base+i]));
        end
        @(negedge clk);
        check_eq("done_fall", MAT_W'(xfer_done), MAT_W'(0));
        check_eq("ready_after", MAT_W'(cmd_ready), MAT_W'(1));
    endtask

    initial begin
        logic [MAT_W-1:0] m;
        int               k;
        int               starts;
        int               len;
        int               base;
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_base  = '0;
        cmd_len   = '0;
        wr_matrix = '0;
        ref_buf   = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", MAT_W'(cmd_ready), MAT_W'(1));
        check_eq("rst_start", MAT_W'(mem_start), MAT_W'(0));
        check_eq("rst_done", MAT_W'(xfer_done), MAT_W'(0));
        check_eq("rst_addr", MAT_W'(mem_address), MAT_W'(0));
        check_eq("rst_buf", rd_matrix, '0);
        rst_n = 1'b1;

        for (int b = 0; b < 256; b += 25) run_cmd(1'b1, b, (256 - b < 25) ? 256 - b : 25, rand_mat());

        m = rand_mat();
        m[15:0] = 16'h1111; m[31:16] = 16'h2222; m[47:32] = 16'h3333;
        run_cmd(1'b1, 8'h10, 3, m);
        run_cmd(1'b0, 8'h10, 3, rand_mat());
        check_eq("read_word1", MAT_W'(rd_matrix[31:16]), MAT_W'(16'h2222));

        m = '0;
        for (int i = 0; i < MAX_WORDS; i++) m[i*DATA_W +: DATA_W] = DATA_W'(i + 1);
        run_cmd(1'b1, 8'hF0, 25, m);
        run_cmd(1'b1, 8'hE7, 25, m);
        run_cmd(1'b0, 8'hE7, 25, rand_mat());
        check_eq("ram_ff", MAT_W'(mem_ram[255]), MAT_W'(25));

        run_cmd(1'b1, 8'h40, 0, rand_mat());
        run_cmd(1'b0, 8'h40, 26, rand_mat());

        // Command held valid across a len=2 read: the only re-accept is at E+11.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_base = 8'h20; cmd_len = 5'd2;
        model_read(8'h20, 2);
        @(negedge clk);
        k = 1; starts = 0;
        while (k <= 200 && !xfer_done) begin
            if (mem_start) starts++;
            k++;
            @(negedge clk);
        end
        check_eq("held_latency", MAT_W'(k), MAT_W'(10));
        check_eq("held_starts", MAT_W'(starts), MAT_W'(8));
        check_eq("held_buf", rd_matrix, ref_buf);
        @(negedge clk);
        check_eq("held_ready", MAT_W'(cmd_ready), MAT_W'(1));
        check_eq("held_gap", MAT_W'(mem_start), MAT_W'(0));
        @(negedge clk);
        cmd_valid = 1'b0;
        check_eq("held_reaccept", MAT_W'(mem_start), MAT_W'(1));
        check_eq("held_busy", MAT_W'(cmd_ready), MAT_W'(0));
        k = 0;
        while (k < 200 && !xfer_done) begin k++; @(negedge clk); end
        check_eq("held_second_done", MAT_W'(xfer_done), MAT_W'(1));
        check_eq("held_second_buf", rd_matrix, ref_buf);
        repeat (2) @(negedge clk);

        // Reset during word 4 of a len=10 read.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_base = 8'h30; cmd_len = 5'd10;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (16) @(negedge clk);
        check_eq("pre_rst_start", MAT_W'(mem_start), MAT_W'(1));
        check_eq("pre_rst_addr", MAT_W'(mem_address), MAT_W'(8'h33));
        rst_n = 1'b0;
        #1;
        ref_buf = '0;
        check_eq("arst_start", MAT_W'(mem_start), MAT_W'(0));
        check_eq("arst_ready", MAT_W'(cmd_ready), MAT_W'(1));
        check_eq("arst_addr", MAT_W'(mem_address), MAT_W'(0));
        check_eq("arst_buf", rd_matrix, ref_buf);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        repeat (10) begin
            @(negedge clk);
            if (xfer_done || xfer_err || mem_start) k++;
        end
        check_eq("arst_quiet", MAT_W'(k), MAT_W'(0));
        run_cmd(1'b0, 8'h30, 1, rand_mat());

        m = rand_mat();
        m[15:0] = 16'hABCD;
        run_cmd(1'b1, 8'h77, 1, m);
        run_cmd(1'b0, 8'h77, 1, rand_mat());
        check_eq("abcd_readback", MAT_W'(rd_matrix[15:0]), MAT_W'(16'hABCD));

        repeat (30) begin
            len  = $urandom_range(0, 27);
            base = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 255) : ((256 - len + $urandom_range(0, 1)) & 255);
            run_cmd(1'($urandom_range(0, 1)), base, len, rand_mat());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
